point_uart_tx: RTL and testbench
================================

POINT_UART_TX -- requirements
Module: point_uart_tx

Interface
REQ-001 The block SHALL have one parameter line: CLKS_PER_BIT, default 217, clock cycles per UART bit (115200 baud at 25 MHz).
REQ-002 The block SHALL have one clock, clk; reset is asynchronous and active-high, named reset.
REQ-003 Port: clk  input  1  system clock, all logic on rising edge.
REQ-004 Port: reset  input  1  asynchronous active-high reset.
REQ-005 Port: start  input  1  one-cycle request to transmit one frame.
REQ-006 Port: num_pts  input  11  point count for the frame, sampled when start is accepted.
REQ-007 Port: index  output  11  point-memory read address.
REQ-008 Port: point  input  30  point-memory read data, valid one cycle after index changes; [29:24] brightness, [23:12] x, [11:0] y.
REQ-009 Port: busy  output  1  high from accepted start through the end of the last stop bit.
REQ-010 Port: done  output  1  one-cycle pulse at frame completion.
REQ-011 Port: tx  output  1  UART serial out, 8N1, LSB first, idle high.

Function
REQ-012 Frame format SHALL be a 2-byte count {5'b0, num_pts} MSB byte first, then num_pts points of 4 bytes each, each point sent as {2'b0, point} MSB byte first.
REQ-013 Frame FSM SHALL use states IDLE, HDR_HI, HDR_LO, FETCH, PT_B3, PT_B2, PT_B1, PT_B0, FIN.
REQ-014 In IDLE, start=1 SHALL latch num_pts, clear index to 0, assert busy, and enter HDR_HI on the next edge.
REQ-015 start SHALL be ignored whenever busy=1.
REQ-016 The byte serializer SHALL drive the start bit (0) for CLKS_PER_BIT cycles, then 8 data bits LSB first, then the stop bit (1), each for exactly CLKS_PER_BIT cycles, so one byte takes 10*CLKS_PER_BIT cycles.
REQ-017 The tx falling edge of the first start bit SHALL occur on the clock edge one cycle after the start sample edge.
REQ-018 Bytes SHALL be sent back-to-back: the next start bit begins on the cycle immediately after the previous stop bit ends, with no idle gap inside a frame.
REQ-019 After HDR_LO, if the latched count is 0, the FSM SHALL go to FIN; otherwise it SHALL go to FETCH.
REQ-020 FETCH SHALL last one cycle and register point into a 32-bit shift word; this fetch SHALL overlap the last stop bit of the previous byte so that REQ-018 holds.
REQ-021 After PT_B0, index SHALL increment by 1; if the new index equals the latched count, the FSM SHALL go to FIN, otherwise to FETCH.
REQ-022 index SHALL be stable during each point's four bytes and SHALL not exceed count-1 while a point is being fetched.
REQ-023 FIN SHALL pulse done for one cycle, deassert busy in the same cycle, and return to IDLE with tx=1.
REQ-024 Changes to num_pts or point outside their sample cycles SHALL NOT affect the frame in progress.
REQ-025 The baud counter SHALL be wide enough for CLKS_PER_BIT up to 65535 and SHALL wrap to 0 at the end of each bit.

Reset
REQ-026 Asserting reset SHALL immediately force tx=1, busy=0, done=0, index=0, state=IDLE, and clear all counters, including mid-byte and mid-frame.
REQ-027 After reset deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-028 CLKS_PER_BIT=4, num_pts=0, pulse start -> tx carries bytes 00 00 (80 cycles), then done pulses once, and busy falls in the same cycle.
REQ-029 CLKS_PER_BIT=4, num_pts=1, point=30'h3FABC123 -> tx carries bytes 00 01 3F AB C1 23 (240 cycles, no gaps), index=0 throughout, and done pulses once.
REQ-030 num_pts=3 with memory model latency 1 -> index goes 0,1,2; 14 bytes are sent; each point's bytes match the memory contents; and index never reaches 3 during a fetch.
REQ-031 A second start pulse and a change in num_pts mid-frame -> both are ignored, and the frame completes with the original count.
REQ-032 Reset asserted mid-data-bit of byte 3 -> tx=1 and busy=0 immediately; a new start then produces a correct complete frame.
REQ-033 Bit timing check: the sampler at the center of each bit recovers every byte, each bit lasts exactly CLKS_PER_BIT cycles, and the first start bit begins exactly one cycle after the start edge.

Source files
------------

// File: rtl/point_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : point_uart_tx
// Brief    : Streams a point list over an 8N1 UART. A frame is a 2-byte point
//            count (MSB first) followed by each point as 4 bytes, MSB first.
//            Points are read from an external memory with one cycle latency.
// Revision : 1.0 - initial release
// ============================================================================
module point_uart_tx #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] num_pts,
  output logic [10:0] index,
  input  logic [29:0] point,
  output logic        busy,
  output logic        done,
  output logic        tx
);

  localparam logic [15:0] c_baud_last    = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] c_baud_prelast = 16'(CLKS_PER_BIT - 2);
  localparam logic [3:0]  c_bit_stop     = 4'd9;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    HDR_HI = 4'd1,
    HDR_LO = 4'd2,
    FETCH  = 4'd3,
    PT_B3  = 4'd4,
    PT_B2  = 4'd5,
    PT_B1  = 4'd6,
    PT_B0  = 4'd7,
    FIN    = 4'd8
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [10:0] r_count;
  logic [10:0] r_index;
  logic [23:0] r_word;

  logic        r_ser_active;
  logic [3:0]  r_bit_cnt;
  logic [15:0] r_baud_cnt;
  logic [7:0]  r_shift;
  logic        r_tx;

  logic        w_accept;
  logic        w_load;
  logic [7:0]  w_load_byte;
  logic        w_fetch;
  logic        w_word_shift;
  logic        w_idx_inc;
  logic        w_byte_end;
  logic        w_pre_end;
  logic [10:0] w_idx_next;
  logic        w_last_point;

  // Last cycle of the stop bit, and the cycle just before it. The fetch and
  // index advance are keyed off the latter so the next start bit follows
  // the stop bit with no gap.
  assign w_byte_end   = r_ser_active && (r_bit_cnt == c_bit_stop) && (r_baud_cnt == c_baud_last);
  assign w_pre_end    = r_ser_active && (r_bit_cnt == c_bit_stop) && (r_baud_cnt == c_baud_prelast);
  assign w_idx_next   = r_index + 11'd1;
  assign w_last_point = (w_idx_next == r_count);

  assign index = r_index;
  assign busy  = (r_state != IDLE) && (r_state != FIN);
  assign done  = (r_state == FIN);
  assign tx    = r_tx;

  // Frame state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Frame sequencing: picks the next state and the byte handed to the serializer.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_load       = 1'b0;
    w_load_byte  = 8'h00;
    w_fetch      = 1'b0;
    w_word_shift = 1'b0;
    w_idx_inc    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_next_state = HDR_HI;
        end
      end
      HDR_HI: begin
        // First byte waits one cycle after acceptance so the start bit lands
        // on the edge after the start sample.
        if (!r_ser_active) begin
          w_load      = 1'b1;
          w_load_byte = {5'b0, r_count[10:8]};
        end else if (w_byte_end) begin
          w_load       = 1'b1;
          w_load_byte  = r_count[7:0];
          w_next_state = HDR_LO;
        end
      end
      HDR_LO: begin
        if (r_count == 11'd0) begin
          if (w_byte_end) w_next_state = FIN;
        end else if (w_pre_end) begin
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        // Coincides with the last stop-bit cycle of the previous byte.
        w_fetch      = 1'b1;
        w_load       = 1'b1;
        w_load_byte  = {2'b00, point[29:24]};
        w_next_state = PT_B3;
      end
      PT_B3: begin
        if (w_byte_end) begin
          w_load       = 1'b1;
          w_load_byte  = r_word[23:16];
          w_word_shift = 1'b1;
          w_next_state = PT_B2;
        end
      end
      PT_B2: begin
        if (w_byte_end) begin
          w_load       = 1'b1;
          w_load_byte  = r_word[23:16];
          w_word_shift = 1'b1;
          w_next_state = PT_B1;
        end
      end
      PT_B1: begin
        if (w_byte_end) begin
          w_load       = 1'b1;
          w_load_byte  = r_word[23:16];
          w_word_shift = 1'b1;
          w_next_state = PT_B0;
        end
      end
      PT_B0: begin
        // The last point keeps index at count-1 and finishes its stop bit.
        if (w_last_point) begin
          if (w_byte_end) w_next_state = FIN;
        end else if (w_pre_end) begin
          w_idx_inc    = 1'b1;
          w_next_state = FETCH;
        end
      end
      FIN: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Latched count, point-memory address and the remaining bytes of the point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 11'd0;
      r_index <= 11'd0;
      r_word  <= 24'd0;
    end else begin
      if (w_accept) begin
        r_count <= num_pts;
        r_index <= 11'd0;
      end else if (w_idx_inc) begin
        r_index <= w_idx_next;
      end
      if (w_fetch)           r_word <= point[23:0];
      else if (w_word_shift) r_word <= {r_word[15:0], 8'h00};
    end
  end

  // Byte serializer: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ser_active <= 1'b0;
      r_bit_cnt    <= 4'd0;
      r_baud_cnt   <= 16'd0;
      r_shift      <= 8'h00;
      r_tx         <= 1'b1;
    end else if (w_load) begin
      r_ser_active <= 1'b1;
      r_bit_cnt    <= 4'd0;
      r_baud_cnt   <= 16'd0;
      r_shift      <= w_load_byte;
      r_tx         <= 1'b0;
    end else if (r_ser_active) begin
      if (r_baud_cnt == c_baud_last) begin
        r_baud_cnt <= 16'd0;
        if (r_bit_cnt == c_bit_stop) begin
          r_ser_active <= 1'b0;
          r_bit_cnt    <= 4'd0;
          r_tx         <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 4'd1;
          r_tx      <= (r_bit_cnt == 4'd8) ? 1'b1 : r_shift[0];
          r_shift   <= {1'b0, r_shift[7:1]};
        end
      end else begin
        r_baud_cnt <= r_baud_cnt + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_point_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_point_uart_tx
// Brief    : Directed bench for point_uart_tx with CLKS_PER_BIT = 4. Captures
//            tx/busy/done/index every falling edge and decodes each frame.
// Revision : 1.0 - initial release
// ============================================================================
module tb_point_uart_tx;

  localparam int C      = 4;
  localparam int LOGMAX = 700;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [10:0] num_pts;
  logic [10:0] index;
  logic [29:0] point;
  logic        busy;
  logic        done;
  logic        tx;

  logic [29:0] mem [0:7];
  logic [7:0]  exp_bytes [0:15];

  logic        log_tx   [0:LOGMAX-1];
  logic        log_busy [0:LOGMAX-1];
  logic        log_done [0:LOGMAX-1];
  logic [10:0] log_idx  [0:LOGMAX-1];

  int n_tests = 0;
  int n_fail  = 0;

  point_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .num_pts (num_pts),
    .index   (index),
    .point   (point),
    .busy    (busy),
    .done    (done),
    .tx      (tx)
  );

  always #5 clk = ~clk;

  // Memory model: data for a new index appears half a cycle later, i.e. in
  // time for the following rising edge but not the one that moved index.
  always @(negedge clk) point = mem[index];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulses start (caller is at a falling edge), logs one frame and checks it
  // against exp_bytes. inject_at > 0 re-pulses start with a new count mid-frame.
  task automatic run_frame(input string tag, input logic [10:0] n, input int nbytes,
                           input int inject_at);
    int          ncap;
    int          done_at;
    int          done_cnt;
    int          max_idx;
    int          base;
    int          ctr;
    bit          timing_ok;
    logic [9:0]  fr;
    start   = 1'b1;
    num_pts = n;
    @(posedge clk);
    @(negedge clk);
    start    = 1'b0;
    num_pts  = ~n;
    ncap     = 0;
    done_at  = -1;
    done_cnt = 0;
    while (ncap < LOGMAX) begin
      log_tx[ncap]   = tx;
      log_busy[ncap] = busy;
      log_done[ncap] = done;
      log_idx[ncap]  = index;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = ncap;
      end
      ncap++;
      if (done_at >= 0 && ncap > done_at + 2) break;
      if (inject_at > 0 && ncap == inject_at) begin
        start   = 1'b1;
        num_pts = 11'd5;
      end else if (inject_at > 0 && ncap == inject_at + 1) begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, " done_seen"}, 32'(done_at >= 0), 32'd1);
    if (done_at < 0) return;
    check({tag, " idle_before_start"}, 32'(log_tx[0]), 32'd1);
    check({tag, " busy_after_accept"}, 32'(log_busy[0]), 32'd1);
    check({tag, " done_cycle"}, 32'(done_at), 32'(1 + 10 * C * nbytes));
    check({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " busy_last_stop"}, 32'(log_busy[done_at - 1]), 32'd1);
    check({tag, " busy_at_done"}, 32'(log_busy[done_at]), 32'd0);
    check({tag, " tx_at_done"}, 32'(log_tx[done_at]), 32'd1);
    timing_ok = 1'b1;
    max_idx   = 0;
    for (int b = 0; b < nbytes; b++) begin
      base = 1 + 10 * C * b;
      for (int k = 0; k < 10; k++) begin
        fr[k] = log_tx[base + C * k + C / 2];
        for (int s = 0; s < C; s++)
          if (log_tx[base + C * k + s] !== fr[k]) timing_ok = 1'b0;
      end
      check($sformatf("%s byte%0d", tag, b), 32'(fr), 32'({1'b1, exp_bytes[b], 1'b0}));
      ctr = base + C * 5;
      check($sformatf("%s index_byte%0d", tag, b), 32'(log_idx[ctr]),
            32'((b < 2) ? 0 : (b - 2) / 4));
    end
    check({tag, " bit_timing"}, 32'(timing_ok), 32'd1);
    for (int i = 0; i <= done_at; i++)
      if (int'(log_idx[i]) > max_idx) max_idx = int'(log_idx[i]);
    check({tag, " index_max"}, 32'(max_idx), 32'((n == 11'd0) ? 0 : int'(n) - 1));
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    num_pts = 11'd0;
    mem[0] = 30'h3FABC123;
    mem[1] = 30'h2ABCDEF0;
    mem[2] = 30'h15A5A5A5;
    for (int i = 3; i < 8; i++) mem[i] = 30'h3FFFFFFF;
    repeat (3) @(negedge clk);
    check("reset tx", 32'(tx), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset index", 32'(index), 32'd0);
    reset = 1'b0;

    // Empty frame: header only.
    exp_bytes[0] = 8'h00; exp_bytes[1] = 8'h00;
    run_frame("n0", 11'd0, 2, 0);
    repeat (3) @(negedge clk);

    // Single point.
    exp_bytes[2] = 8'h3F; exp_bytes[3] = 8'hAB; exp_bytes[4] = 8'hC1; exp_bytes[5] = 8'h23;
    exp_bytes[0] = 8'h00; exp_bytes[1] = 8'h01;
    run_frame("n1", 11'd1, 6, 0);
    repeat (2) @(negedge clk);

    // Three points from memory.
    mem[0] = 30'h01234567;
    exp_bytes[0]  = 8'h00; exp_bytes[1]  = 8'h03;
    exp_bytes[2]  = 8'h01; exp_bytes[3]  = 8'h23; exp_bytes[4]  = 8'h45; exp_bytes[5]  = 8'h67;
    exp_bytes[6]  = 8'h2A; exp_bytes[7]  = 8'hBC; exp_bytes[8]  = 8'hDE; exp_bytes[9]  = 8'hF0;
    exp_bytes[10] = 8'h15; exp_bytes[11] = 8'hA5; exp_bytes[12] = 8'hA5; exp_bytes[13] = 8'hA5;
    run_frame("n3", 11'd3, 14, 0);
    @(negedge clk);

    // Restart and count change mid-frame must be ignored.
    exp_bytes[1] = 8'h02;
    run_frame("inject", 11'd2, 10, 100);
    repeat (4) @(negedge clk);

    // Reset in data bit 6 of byte 3 (0x3F, bit 6 is 0).
    mem[0] = 30'h3FABC123;
    start   = 1'b1;
    num_pts = 11'd1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (1 + 10 * C * 2 + C * 7 + 1) @(negedge clk);
    check("pre_reset tx", 32'(tx), 32'd0);
    check("pre_reset busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("midreset tx", 32'(tx), 32'd1);
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset index", 32'(index), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    exp_bytes[0] = 8'h00; exp_bytes[1] = 8'h01;
    exp_bytes[2] = 8'h3F; exp_bytes[3] = 8'hAB; exp_bytes[4] = 8'hC1; exp_bytes[5] = 8'h23;
    run_frame("after_reset", 11'd1, 6, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
